om_range_ctrl: RTL
==================

Name: om_range_ctrl

Overview:
- Controller and arbiter in front of the object-range circular buffer used for memory-safety checking.
- Accepts allocation registrations (base, size) from the allocation-tracking path and address checks from the LSU check path, and sequences them onto the buffer's single write port and single find port.
- Converts size to an inclusive last address and classifies each checked address as in-range, object-start or violation inside a guarded region.
- Tracks fill level and wrap-around of the buffer.

Parameters:
- DEPTH, 64, entry count of the attached range buffer; fill counter saturates here.
- MAX_WAIT, 8, consecutive cycles an allocation request may lose arbitration before it is forced to win.
- GUARD_BASE, 32'h8000_0000, lowest address of the guarded region (inclusive).
- GUARD_LIMIT, 32'h8FFF_FFFF, highest address of the guarded region (inclusive).

Ports:
- clk_i  in  1  clock
- rst_i  in  1  synchronous active-high reset
- alloc_valid_i  in  1  allocation request valid
- alloc_ready_o  out  1  allocation accepted this cycle
- alloc_base_i  in  32  object base address
- alloc_size_i  in  32  object size in bytes
- alloc_done_o  out  1  one-cycle pulse: entry written
- alloc_err_o  out  1  one-cycle pulse: request rejected
- chk_valid_i  in  1  check request valid
- chk_ready_o  out  1  check accepted this cycle
- chk_addr_i  in  32  address to check
- chk_rvalid_o  out  1  check response valid
- chk_rready_i  in  1  response consumed
- chk_in_range_o  out  1  address inside a stored range
- chk_is_first_o  out  1  address equals a stored base
- chk_violation_o  out  1  address in guarded region and not in any range
- buf_en_write_o  out  1  buffer write enable
- buf_addr_first_o  out  32  buffer write: first address
- buf_addr_last_o  out  32  buffer write: last address
- buf_find_o  out  1  buffer lookup strobe
- buf_find_addr_o  out  32  buffer lookup address
- buf_in_range_i  in  1  buffer result: in range (combinational)
- buf_is_first_i  in  1  buffer result: is first (combinational)
- fill_o  out  $clog2(DEPTH+1)  valid entries, saturating at DEPTH
- wrapped_o  out  1  sticky: an entry has been overwritten

Behaviour:
- Reset (rst_i high at a clock edge):
  - State goes to IDLE.
  - All outputs and registers go to 0, including fill_o, wrapped_o, the wait counter and the response register.
  - Reset has priority over any in-flight operation; a pending response or write is dropped.
- FSM states: IDLE, WRITE, LOOKUP, RESP.
- IDLE arbitration:
  - Only one of alloc_ready_o / chk_ready_o may be high in a cycle.
  - A check wins over an allocation unless wait_cnt == MAX_WAIT, in which case the allocation wins.
  - wait_cnt increments each cycle alloc_valid_i is high and not granted, saturates at MAX_WAIT, and clears on grant or when alloc_valid_i is low.
- Allocation grant in IDLE:
  - Compute last = base + size - 1 in 33 bits and register base/last.
  - If size == 0 or bit 32 of the sum is set: pulse alloc_err_o next cycle, no write, stay IDLE.
  - Otherwise go to WRITE.
- WRITE (one cycle):
  - buf_en_write_o = 1, with the registered first/last on buf_addr_first_o / buf_addr_last_o.
  - alloc_done_o = 1.
  - fill_o increments unless already at DEPTH; if already at DEPTH, set wrapped_o.
  - Return to IDLE.
- Check grant in IDLE:
  - Register chk_addr_i and go to LOOKUP.
- LOOKUP (one cycle):
  - buf_find_o = 1 and buf_find_addr_o = registered address.
  - Sample buf_in_range_i / buf_is_first_i into the response register.
  - violation = (GUARD_BASE <= addr <= GUARD_LIMIT) && !buf_in_range_i.
  - Go to RESP.
- RESP:
  - chk_rvalid_o = 1; response fields held stable until chk_rready_i is high.
  - Then go to IDLE; no new grant is issued in that same cycle.
- Outside RESP, chk_in_range_o, chk_is_first_o and chk_violation_o read 0.
- Latency:
  - Check accepted at cycle T → chk_rvalid_o at T+2.
  - Allocation accepted at T → write and alloc_done_o at T+1.
  - Minimum spacing between grants is 2 cycles (allocation) or 3 cycles (check).
- Write/lookup ordering: never both in the same cycle. A check granted after an allocation's WRITE observes that entry.
- Boundaries:
  - buf_addr_* and buf_find_addr_o hold their last values when not strobed.
  - size = 1 gives last = base.
  - base = 32'hFFFF_FFFF with size = 1 is accepted.
  - base = 32'hFFFF_FFFF with size = 2 is rejected.
  - Requesters keep valid/data stable until ready.

Test Plan:
- Reset, then alloc base=32'h8000_0100 size=32'h40 → alloc_ready at T, buf_en_write at T+1 with first=32'h8000_0100 last=32'h8000_013F, alloc_done pulse, fill_o=1.
- After previous, check addr=32'h8000_0120 → chk_rvalid at T+2 with in_range=1 is_first=0 violation=0; addr=32'h8000_0100 → is_first=1.
- Check addr=32'h8000_0200 (guarded, unmapped) → violation=1; addr=32'h0000_1000 → in_range=0 violation=0.
- alloc size=0 and alloc base=32'hFFFF_FFF0 size=32'h20 → alloc_err pulse each, no buf_en_write, fill_o unchanged.
- chk_valid held high continuously with alloc_valid high → alloc granted after wait_cnt reaches MAX_WAIT=8; hold chk_rready low 5 cycles → response stable, no grants.
- 65 successful allocs with DEPTH=64 → fill_o=64 after the 64th, wrapped_o=1 after the 65th; rst_i asserted in LOOKUP → next cycle IDLE, chk_rvalid=0, fill_o=0, wrapped_o=0.

Source files
------------

// File: rtl/om_range_ctrl.sv
// Arbitrating controller for the object-range circular buffer: sequences
// allocation writes and address lookups onto the buffer's single ports.
module om_range_ctrl #(
   parameter int          DEPTH       = 64,
   parameter int          MAX_WAIT    = 8,
   parameter logic [31:0] GUARD_BASE  = 32'h8000_0000,
   parameter logic [31:0] GUARD_LIMIT = 32'h8FFF_FFFF,
   localparam int         FILL_W      = $clog2(DEPTH + 1),
   localparam int         WAIT_W      = $clog2(MAX_WAIT + 1)
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              alloc_valid_i,
   output logic              alloc_ready_o,
   input  logic [31:0]       alloc_base_i,
   input  logic [31:0]       alloc_size_i,
   output logic              alloc_done_o,
   output logic              alloc_err_o,
   input  logic              chk_valid_i,
   output logic              chk_ready_o,
   input  logic [31:0]       chk_addr_i,
   output logic              chk_rvalid_o,
   input  logic              chk_rready_i,
   output logic              chk_in_range_o,
   output logic              chk_is_first_o,
   output logic              chk_violation_o,
   output logic              buf_en_write_o,
   output logic [31:0]       buf_addr_first_o,
   output logic [31:0]       buf_addr_last_o,
   output logic              buf_find_o,
   output logic [31:0]       buf_find_addr_o,
   input  logic              buf_in_range_i,
   input  logic              buf_is_first_i,
   output logic [FILL_W-1:0] fill_o,
   output logic              wrapped_o
);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      WRITE  = 2'd1,
      LOOKUP = 2'd2,
      RESP   = 2'd3
   } state_t;

   state_t              state_reg, state_next;
   logic [WAIT_W-1:0]   wait_cnt_reg;
   logic [31:0]         first_reg, last_reg, find_addr_reg;
   logic                resp_in_range_reg, resp_is_first_reg, resp_violation_reg;
   logic                alloc_err_reg, wrapped_reg;
   logic [FILL_W-1:0]   fill_reg;

   logic                alloc_grant, chk_grant, alloc_bad, in_guard;
   logic [32:0]         alloc_sum;

   // 33-bit sum so that a range crossing the top of the address space is caught
   assign alloc_sum = {1'b0, alloc_base_i} + {1'b0, alloc_size_i} - 33'd1;
   assign alloc_bad = (alloc_size_i == 32'd0) || alloc_sum[32];
   assign in_guard  = (find_addr_reg >= GUARD_BASE) && (find_addr_reg <= GUARD_LIMIT);

   always_comb begin
      state_next  = state_reg;
      alloc_grant = 1'b0;
      chk_grant   = 1'b0;
      case (state_reg)
         IDLE: begin
            if (alloc_valid_i && (!chk_valid_i || wait_cnt_reg == WAIT_W'(MAX_WAIT))) begin
               alloc_grant = 1'b1;
               if (!alloc_bad) state_next = WRITE;
            end else if (chk_valid_i) begin
               chk_grant  = 1'b1;
               state_next = LOOKUP;
            end
         end
         WRITE:   state_next = IDLE;
         LOOKUP:  state_next = RESP;
         RESP:    if (chk_rready_i) state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_reg          <= IDLE;
         wait_cnt_reg       <= '0;
         first_reg          <= '0;
         last_reg           <= '0;
         find_addr_reg      <= '0;
         resp_in_range_reg  <= 1'b0;
         resp_is_first_reg  <= 1'b0;
         resp_violation_reg <= 1'b0;
         alloc_err_reg      <= 1'b0;
         fill_reg           <= '0;
         wrapped_reg        <= 1'b0;
      end else begin
         state_reg     <= state_next;
         alloc_err_reg <= alloc_grant && alloc_bad;

         // Starvation guard: every losing cycle counts, not only IDLE cycles
         if (alloc_grant || !alloc_valid_i)
            wait_cnt_reg <= '0;
         else if (wait_cnt_reg != WAIT_W'(MAX_WAIT))
            wait_cnt_reg <= wait_cnt_reg + WAIT_W'(1);

         if (alloc_grant && !alloc_bad) begin
            first_reg <= alloc_base_i;
            last_reg  <= alloc_sum[31:0];
         end

         if (chk_grant)
            find_addr_reg <= chk_addr_i;

         if (state_reg == LOOKUP) begin
            resp_in_range_reg  <= buf_in_range_i;
            resp_is_first_reg  <= buf_is_first_i;
            resp_violation_reg <= in_guard && !buf_in_range_i;
         end

         if (state_reg == WRITE) begin
            if (fill_reg == FILL_W'(DEPTH))
               wrapped_reg <= 1'b1;
            else
               fill_reg <= fill_reg + FILL_W'(1);
         end
      end
   end

   assign alloc_ready_o    = alloc_grant;
   assign chk_ready_o      = chk_grant;
   assign alloc_done_o     = (state_reg == WRITE);
   assign alloc_err_o      = alloc_err_reg;
   assign buf_en_write_o   = (state_reg == WRITE);
   assign buf_addr_first_o = first_reg;
   assign buf_addr_last_o  = last_reg;
   assign buf_find_o       = (state_reg == LOOKUP);
   assign buf_find_addr_o  = find_addr_reg;
   assign chk_rvalid_o     = (state_reg == RESP);
   assign chk_in_range_o   = (state_reg == RESP) && resp_in_range_reg;
   assign chk_is_first_o   = (state_reg == RESP) && resp_is_first_reg;
   assign chk_violation_o  = (state_reg == RESP) && resp_violation_reg;
   assign fill_o           = fill_reg;
   assign wrapped_o        = wrapped_reg;

endmodule
